bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential multi-digit packed-BCD to binary converter. It is the decode-side counterpart of the BCD adder datapath: BCD sums produced by the adder chain are converted back to plain binary for downstream arithmetic and comparison. The block uses reverse double-dabble, processing one bit per clock (shift right, then subtract 3 from every BCD digit ≥ 8), with a start/ready/valid handshake.

## Interface
- `DIGITS`, default 4: number of packed BCD digits on the input.
- `BIN_W`, default 14: width of the binary result; must satisfy 2^BIN_W > 10^DIGITS − 1 (4 digits → 14 bits).
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a conversion; sampled only while `ready`=1.
- `bcd` input, 4*DIGITS bits: packed BCD operand; digit 0 is in `bcd[3:0]`. Sampled on the accepting edge only.
- `ready` output, 1 bit: high in IDLE; the block can accept `start`.
- `valid` output, 1 bit: one-cycle pulse; `bin` holds a new result.
- `bin` output, BIN_W bits: binary result; holds its value until the next `valid`.
- `err` output, 1 bit: invalid-digit flag, qualified by `valid` (see Configuration).

## Operation
- States: IDLE → BUSY → DONE → IDLE.
- IDLE: `ready`=1. When `start`=1 on an edge:
  - load the BCD shift register with `bcd`;
  - clear the 4*DIGITS-bit binary shift register;
  - set iteration counter = 0;
  - go to BUSY.
- BUSY: each edge performs one iteration:
  - shift the concatenation {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg;
  - then, for each digit of the shifted bcd_reg with value ≥ 8, subtract 3 (4-bit, no borrow between digits);
  - increment the counter.
  - After iteration 4*DIGITS (counter wraps from 4*DIGITS−1), go to DONE and register `bin` = bin_reg[BIN_W-1:0] computed on that same edge.
- DONE: `valid`=1 for exactly one cycle, then IDLE on the next edge.
- `start` in BUSY or DONE is ignored; no queuing.
- `bcd` changes after acceptance do not affect the conversion in flight.
- Reset, asserted at any time including mid-conversion, takes effect immediately:
  - state IDLE, counter 0, shift registers 0;
  - `bin`=0, `valid`=0, `err`=0, `ready`=1.
  - The aborted conversion produces no `valid`.
- Arithmetic: correction is per-nibble and unsigned. No overflow is possible for valid BCD input because of the BIN_W rule.

## Timing
- Accepting edge k (`start`=1 and `ready`=1) → iterations on edges k+1 … k+4*DIGITS.
- `valid` is high in the cycle after edge k+4*DIGITS. With defaults: edge k+16, so latency is 17 cycles from acceptance to `valid`.
- `ready` falls the cycle after edge k. It rises again after edge k+4*DIGITS+1, the DONE → IDLE edge.
- Back-to-back throughput: one conversion per 4*DIGITS+2 cycles. `start` held high is accepted on the first cycle `ready` is 1.
- `valid` and `ready` are never high in the same cycle.
- `bin` and `err` change only on the edge that enters DONE.

## Configuration
- Macro `BCD2BIN_CHECK_EN`.
- Defined:
  - on the accepting edge, any digit of `bcd` > 9 sets an internal error bit;
  - on entering DONE, `err` = that bit, and `bin` is forced to 0 instead of the computed value;
  - conversion timing is unchanged.
- Undefined:
  - `err` is tied to 0;
  - no digit check is made; non-BCD nibbles run through the algorithm unchanged and `bin` is whatever it produces.

## Test plan
- `bcd`=0x0042, pulse `start` → `valid` exactly 17 cycles after acceptance, `bin`=0x002A, `err`=0.
- `bcd`=0x9999 → `bin`=0x270F; `bcd`=0x0000 → `bin`=0x0000; `bcd`=0x1234 → `bin`=0x04D2.
- Hold `start`=1 with `bcd`=0x0007 then 0x0100 → two conversions 18 cycles apart, `bin`=0x0007 then 0x0064. `bcd` changed mid-BUSY does not alter the first result.
- Assert `rst` at iteration 8 of a 0x9999 conversion → `ready`=1, `bin`=0, `valid` never pulses. A new 0x0005 conversion yields `bin`=0x0005.
- With `BCD2BIN_CHECK_EN`: `bcd`=0x12A4 → `valid` with `err`=1, `bin`=0. A following 0x0010 → `err`=0, `bin`=0x000A.
- `start` pulsed during BUSY and during DONE → ignored: exactly one `valid` per accepted request, and `bin` stable between `valid` pulses.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Start/ready/valid handshake bundle for the bcd_to_bin converter.
// master drives the request (start, bcd); slave returns ready, valid, bin and err.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ready;
  logic                  valid;
  logic [BIN_W-1:0]      bin;
  logic                  err;

  modport master (
    output start, bcd,
    input  ready, valid, bin, err
  );

  modport slave (
    input  start, bcd,
    output ready, valid, bin, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Optional digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic         clk,
  input  logic         rst,
  bcd_to_bin_if.slave  bus
);

  localparam int NBITS = 4 * DIGITS;
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   bcd_q, bcd_d;
  logic [NBITS-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   res_q, res_d;

  logic [2*NBITS-1:0] shifted;
  logic [NBITS-1:0]   bcd_corr;
  logic [NBITS-1:0]   bin_sh;

`ifdef BCD2BIN_CHECK_EN
  logic chk_q, chk_d;
  logic err_q, err_d;

  function automatic logic has_bad_digit(input logic [NBITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  // One reverse double-dabble step: halve the pair, then fix every digit that
  // received the incoming bit (+8 must become +5).
  always_comb begin
    shifted  = {bcd_q, bin_q} >> 1;
    bcd_corr = shifted[2*NBITS-1:NBITS];
    bin_sh   = shifted[NBITS-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_corr[4*i+3]) bcd_corr[4*i +: 4] = bcd_corr[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef BCD2BIN_CHECK_EN
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d   = bus.bcd;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef BCD2BIN_CHECK_EN
          chk_d   = has_bad_digit(bus.bcd);
`endif
        end
      end
      BUSY: begin
        bcd_d = bcd_corr;
        bin_d = bin_sh;
        cnt_d = (cnt_q == LAST_ITER) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
`ifdef BCD2BIN_CHECK_EN
          res_d   = chk_q ? '0 : bin_sh[BIN_W-1:0];
          err_d   = chk_q;
`else
          res_d   = bin_sh[BIN_W-1:0];
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the shift registers are ordinary flops, so they take the async reset
  // like the rest of the state; an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
`ifdef BCD2BIN_CHECK_EN
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.valid = (state_q == DONE);
  assign bus.bin   = res_q;
`ifdef BCD2BIN_CHECK_EN
  assign bus.err   = err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (default DIGITS=4, BIN_W=14).
// Expected values are hand-computed decimal conversions of the BCD operands.
module tb_bcd_to_bin;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  bcd_to_bin_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle from IDLE, wait (bounded) for valid, then check
  // the DONE -> IDLE return. lat counts cycles from acceptance to valid.
  task automatic convert(input logic [15:0] v, output logic [13:0] r,
                         output logic e, output int lat);
    @(negedge clk);
    bus.bcd   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
    lat = 1;
    while (bus.valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = bus.bin;
    e = bus.err;
    check("ready_low_while_valid", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    check("valid_one_cycle", {31'd0, bus.valid}, 32'd0);
    check("ready_back", {31'd0, bus.ready}, 32'd1);
  endtask

  initial begin
    logic [13:0] r;
    logic        e;
    logic [13:0] prev;
    logic [13:0] res;
    int          lat;
    int          n;
    int          nvalid;
    int          vat;
    int          changes;

    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bcd   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_bin",   {18'd0, bus.bin},   32'd0);
    check("rst_err",   {31'd0, bus.err},   32'd0);
    rst = 1'b0;

    // Basic conversions
    convert(16'h0042, r, e, lat);
    check("lat_0042", lat, 32'd17);
    check("bin_0042", {18'd0, r}, 32'h002A);
    check("err_0042", {31'd0, e}, 32'd0);

    convert(16'h9999, r, e, lat);
    check("lat_9999", lat, 32'd17);
    check("bin_9999", {18'd0, r}, 32'h270F);

    convert(16'h0000, r, e, lat);
    check("bin_0000", {18'd0, r}, 32'h0000);

    convert(16'h1234, r, e, lat);
    check("bin_1234", {18'd0, r}, 32'h04D2);

    // start held high: back-to-back conversions, bcd changed mid-BUSY
    @(negedge clk);
    bus.bcd   = 16'h0007;
    bus.start = 1'b1;
    @(negedge clk);
    bus.bcd = 16'h0100;
    n = 1;
    while (bus.valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_lat1", n, 32'd17);
    check("hold_bin1", {18'd0, bus.bin}, 32'h0007);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.valid !== 1'b1 && n < 40);
    bus.start = 1'b0;
    check("hold_spacing", n, 32'd18);
    check("hold_bin2", {18'd0, bus.bin}, 32'h0064);
    nvalid = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nvalid++;
    end
    check("hold_no_extra_valid", nvalid, 32'd0);

    // Reset after 8 iterations of a 0x9999 conversion
    @(negedge clk);
    bus.bcd   = 16'h9999;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_valid", {31'd0, bus.valid}, 32'd0);
    check("abort_bin",   {18'd0, bus.bin},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nvalid++;
    end
    check("abort_no_valid", nvalid, 32'd0);
    check("abort_bin_held", {18'd0, bus.bin}, 32'd0);
    convert(16'h0005, r, e, lat);
    check("after_abort_bin", {18'd0, r}, 32'h0005);
    check("after_abort_lat", lat, 32'd17);

    // start pulsed during BUSY and DONE is ignored; bin stable between valids
    @(negedge clk);
    prev      = bus.bin;
    bus.bcd   = 16'h1234;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nvalid  = 0;
    vat     = 0;
    changes = 0;
    res     = '0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.valid === 1'b1) begin
        nvalid++;
        vat = i;
        res = bus.bin;
      end else if (bus.bin !== ((nvalid == 0) ? prev : res)) begin
        changes++;
      end
      if (i == 5) bus.bcd = 16'h0042;
      bus.start = (i == 5) || (bus.valid === 1'b1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ign_valid_count", nvalid, 32'd1);
    check("ign_valid_at", vat, 32'd17);
    check("ign_bin", {18'd0, res}, 32'h04D2);
    check("ign_bin_stable", changes, 32'd0);
    check("ign_ready_idle", {31'd0, bus.ready}, 32'd1);

    // Non-BCD digit handling
    convert(16'h12A4, r, e, lat);
    check("bad_lat", lat, 32'd17);
`ifdef BCD2BIN_CHECK_EN
    check("bad_err", {31'd0, e}, 32'd1);
    check("bad_bin", {18'd0, r}, 32'd0);
`else
    check("bad_err", {31'd0, e}, 32'd0);
    check("bad_bin", {18'd0, r}, 32'h0518);
`endif
    convert(16'h0010, r, e, lat);
    check("good_err", {31'd0, e}, 32'd0);
    check("good_bin", {18'd0, r}, 32'h000A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
